temp_feeder: RTL and testbench

Paced sample source that drives the temperature averager's sample port. Upstream logic pushes signed temperature samples through a valid/ready handshake into an internal FIFO. The feeder clamps each sample to a legal range, then presents one sample on `tempvalue` with a single-cycle `shift_en` strobe every `DIV` clocks. It is the writer side of the averager's `tempvalue`/`shift_en` interface.

---
 rtl/temp_pkg.sv | 24 ++
 rtl/temp_fifo.sv | 72 +++++++
 rtl/temp_feeder.sv | 117 +++++++++++
 tb/tb_temp_feeder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_pkg.sv
// Shared temperature-sample definitions used by the feeder and the averager.
// Samples are two's complement; the clamp saturates into a legal window.
package temp_pkg;

  localparam int TEMP_W   = 10;
  localparam int TEMP_MIN = -400;
  localparam int TEMP_MAX = 400;

  typedef logic signed [TEMP_W-1:0] temp_t;

  // Saturate v into [lo, hi]; compares stay at sample width, no widening.
  function automatic temp_t temp_clamp(input temp_t v, input temp_t lo, input temp_t hi);
    temp_t r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/temp_fifo.sv
// Synchronous sample FIFO with flush; pointers wrap naturally (DEPTH is a power of two).
module temp_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [W-1:0]          wr_data,
  output logic [W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against occupancy; flush overrides both.
  always_comb begin
    do_push_s = push && (count_r != DEPTH_C) && !flush;
    do_pop_s  = pop && (count_r != CW'(0)) && !flush;
  end

  // Storage array, left unreset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = (count_r == DEPTH_C);
  assign empty   = (count_r == CW'(0));

endmodule

// File: rtl/temp_feeder.sv
// Paced sample source for the temperature averager: clamps incoming samples,
// queues them, and presents one per DIV clocks with a single-cycle shift_en.
module temp_feeder
  import temp_pkg::*;
#(
  parameter int W     = TEMP_W,
  parameter int DEPTH = 8,
  parameter int DIV   = 2,
  parameter int TMIN  = TEMP_MIN,
  parameter int TMAX  = TEMP_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [W-1:0]           tempvalue,
  output logic                   shift_en,
  output logic [$clog2(DEPTH):0] count,
  output logic                   clipped,
  output logic                   underrun
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam temp_t TMIN_T = temp_t'(TMIN);
  localparam temp_t TMAX_T = temp_t'(TMAX);

  logic [DW-1:0] div_cnt_r;
  logic          started_r;
  logic [W-1:0]  tempvalue_r;
  logic          shift_en_r;
  logic          clipped_r;
  logic          underrun_r;

  logic          tick_s;
  logic          push_s;
  logic          pop_s;
  logic          clip_s;
  logic          full_s;
  logic          empty_s;
  logic [W-1:0]  clamped_s;
  logic [W-1:0]  head_s;

  // Clamp the incoming sample and qualify push/pop against FIFO state.
  always_comb begin
    clamped_s = W'(temp_clamp(temp_t'(in_data), TMIN_T, TMAX_T));
    clip_s    = (clamped_s != in_data);
    tick_s    = (div_cnt_r == DIV_LAST);
    push_s    = in_valid && !full_s;
    pop_s     = tick_s && !empty_s;
  end

  temp_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush),
    .wr_data (clamped_s),
    .rd_data (head_s),
    .count   (count),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Pacing counter, output registers and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r   <= DW'(0);
      started_r   <= 1'b0;
      tempvalue_r <= W'(0);
      shift_en_r  <= 1'b0;
      clipped_r   <= 1'b0;
      underrun_r  <= 1'b0;
    end else if (flush) begin
      // tempvalue deliberately holds so the averager never sees a spurious value
      div_cnt_r  <= DW'(0);
      started_r  <= 1'b0;
      shift_en_r <= 1'b0;
      clipped_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (tick_s) begin
        div_cnt_r <= DW'(0);
      end else begin
        div_cnt_r <= div_cnt_r + DW'(1);
      end

      if (pop_s) begin
        tempvalue_r <= head_s;
        shift_en_r  <= 1'b1;
        started_r   <= 1'b1;
      end else begin
        shift_en_r <= 1'b0;
        if (tick_s && started_r) begin
          underrun_r <= 1'b1;
        end
      end

      if (push_s && clip_s) begin
        clipped_r <= 1'b1;
      end
    end
  end

  assign in_ready  = !full_s;
  assign tempvalue = tempvalue_r;
  assign shift_en  = shift_en_r;
  assign clipped   = clipped_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_temp_feeder.sv
// Self-checking bench for temp_feeder: table-driven sample stream with a
// scoreboard queue, plus hand sequences for full, underrun, flush and reset.
module tb_temp_feeder;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [9:0]        in_data;
  logic              in_ready;
  logic              flush;
  logic signed [9:0] tempvalue;
  logic              shift_en;
  logic [3:0]        count;
  logic              clipped;
  logic              underrun;

  logic              s_valid;
  logic [9:0]        s_data;
  logic              s_ready;
  logic              s_flush;
  logic signed [9:0] s_tv;
  logic              s_se;
  logic [3:0]        s_count;
  logic              s_clip;
  logic              s_und;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_q[$];
  int strobe_q[$];
  int prev_tv = 0;

  typedef struct {
    int din;
    int dout;
  } vec_t;
  vec_t tbl[15];

  temp_feeder #(.DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .tempvalue(tempvalue),
    .shift_en(shift_en), .count(count), .clipped(clipped), .underrun(underrun)
  );

  temp_feeder #(.DIV(16)) u_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .flush(s_flush), .tempvalue(s_tv),
    .shift_en(s_se), .count(s_count), .clipped(s_clip), .underrun(s_und)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every strobe must match the oldest accepted sample; tempvalue holds otherwise.
  always @(negedge clk) begin
    int tv;
    tv = tempvalue;
    if (rst_n) begin
      if (shift_en) begin
        strobe_q.push_back(cyc);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL strobe: unexpected strobe with tempvalue %0d, expected no strobe", tv);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (tv !== e) begin
            n_err++;
            $display("FAIL strobe: tempvalue %0d, expected %0d", tv, e);
          end
        end
      end else if (tv !== prev_tv) begin
        n_vec++;
        n_err++;
        $display("FAIL hold: tempvalue %0d changed without strobe, expected %0d", tv, prev_tv);
      end
    end
    prev_tv = tv;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_sample(input int din, input int dexp);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = din[9:0];
      if (in_ready) begin
        exp_q.push_back(dexp);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push: sample %0d never accepted, expected acceptance", din);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic dut_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic slow_strobe(input string name, input int exp);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (s_se) seen = 1'b1;
    end
    check({name, "_seen"}, int'(seen), 1);
    check(name, int'(s_tv), exp);
  endtask

  initial begin
    int push_cyc;
    int base;
    tbl[0]  = '{-262, -262};
    tbl[1]  = '{121, 121};
    tbl[2]  = '{68, 68};
    tbl[3]  = '{367, 367};
    tbl[4]  = '{-84, -84};
    tbl[5]  = '{165, 165};
    tbl[6]  = '{30, 30};
    tbl[7]  = '{450, 400};
    tbl[8]  = '{-500, -400};
    tbl[9]  = '{401, 400};
    tbl[10] = '{-401, -400};
    tbl[11] = '{511, 400};
    tbl[12] = '{-512, -400};
    tbl[13] = '{400, 400};
    tbl[14] = '{-400, -400};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 10'd0; flush = 1'b0;
    s_valid = 1'b0; s_data = 10'd0; s_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tempvalue", int'(tempvalue), 0);
    check("rst_shift_en", int'(shift_en), 0);
    check("rst_count", int'(count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_clipped", int'(clipped), 0);
    check("rst_underrun", int'(underrun), 0);

    // Basic stream, back-to-back pushes
    strobe_q.delete();
    for (int i = 0; i < 7; i++) push_sample(tbl[i].din, tbl[i].dout);
    idle();
    drain("t1_drain");
    check("t1_clipped", int'(clipped), 0);
    check("t1_strobes", strobe_q.size(), 7);
    for (int i = 1; i < 7 && i < strobe_q.size(); i++)
      check("t1_spacing", strobe_q[i] - strobe_q[i-1], 2);

    // Clamp
    push_sample(tbl[7].din, tbl[7].dout);
    idle();
    check("t2_clipped_first", int'(clipped), 1);
    for (int i = 8; i < 13; i++) push_sample(tbl[i].din, tbl[i].dout);
    idle();
    drain("t2_drain");
    check("t2_clipped_sticky", int'(clipped), 1);

    // Exact bounds pass unaltered and do not flag clipping
    dut_flush();
    check("bnd_flush_clipped", int'(clipped), 0);
    for (int i = 13; i < 15; i++) push_sample(tbl[i].din, tbl[i].dout);
    idle();
    drain("bnd_drain");
    check("bnd_clipped", int'(clipped), 0);

    // Full FIFO on the slow instance, pacing aligned by a flush
    @(negedge clk);
    s_flush = 1'b1;
    @(negedge clk);
    s_flush = 1'b0; s_valid = 1'b1; s_data = 10'd1;
    for (int v = 2; v <= 8; v++) begin
      @(negedge clk);
      s_data = 10'(v);
    end
    @(negedge clk);
    s_data = 10'd99;
    check("t3_count_full", int'(s_count), 8);
    check("t3_ready_low", int'(s_ready), 0);
    repeat (3) @(negedge clk);
    check("t3_ninth_rejected", int'(s_count), 8);
    slow_strobe("t3_first_pop", 1);
    check("t3_count_after_pop", int'(s_count), 7);
    check("t3_ready_rise", int'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
    check("t3_count_refill", int'(s_count), 8);
    for (int v = 2; v <= 8; v++) slow_strobe("t3_order", v);
    slow_strobe("t3_last", 99);
    @(negedge clk);
    check("t3_count_empty", int'(s_count), 0);

    // Underrun
    dut_flush();
    repeat (4) @(negedge clk);
    check("t4_no_underrun_before_start", int'(underrun), 0);
    push_sample(121, 121);
    idle();
    drain("t4_drain");
    check("t4_tempvalue", int'(tempvalue), 121);
    repeat (4) @(negedge clk);
    check("t4_underrun", int'(underrun), 1);
    check("t4_shift_en", int'(shift_en), 0);
    check("t4_tempvalue_held", int'(tempvalue), 121);

    // Flush on a tick cycle with data queued
    dut_flush();
    push_sample(450, 400);
    push_sample(-7, -7);
    push_sample(12, 12);
    idle();
    check("t5_first_strobe", int'(shift_en), 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    check("t5_count", int'(count), 0);
    check("t5_shift_en", int'(shift_en), 0);
    check("t5_clipped", int'(clipped), 0);
    check("t5_underrun", int'(underrun), 0);
    check("t5_tempvalue_held", int'(tempvalue), 400);
    repeat (6) @(negedge clk);
    check("t5_count_stays", int'(count), 0);

    // Reset mid-stream
    push_sample(10, 10);
    push_sample(20, 20);
    push_sample(30, 30);
    push_sample(40, 40);
    push_sample(450, 400);
    idle();
    base = strobe_q.size();
    for (int k = 0; k < 20 && strobe_q.size() == base; k++) @(negedge clk);
    check("t6_strobe_before_reset", int'(strobe_q.size() > base), 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_tempvalue", int'(tempvalue), 0);
    check("t6_rst_shift_en", int'(shift_en), 0);
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_in_ready", int'(in_ready), 1);
    check("t6_rst_clipped", int'(clipped), 0);
    check("t6_rst_underrun", int'(underrun), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 10'd68;
    push_cyc = cyc + 1;
    exp_q.push_back(68);
    base = strobe_q.size();
    @(negedge clk);
    in_valid = 1'b0;
    drain("t6_drain");
    if (strobe_q.size() > base)
      check("t6_latency", strobe_q[strobe_q.size()-1] - push_cyc, 2);
    else
      check("t6_latency_strobe", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
